// File: rtl/aha_sram_pkg.sv
// aha_sram_pkg: shared types and helpers for the banked SRAM subsystem.
// Init FSM states, bank-count function, byte-lane write mask expansion.
package aha_sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } init_st_e;

  localparam int MAX_DW = 1024;

  function automatic int nbanks(input int aw, input int baw);
    return 1 << (aw - baw);
  endfunction

  // Active-low byte enables to active-high per-bit write mask.
  function automatic logic [MAX_DW-1:0] be_mask(
    input logic [MAX_DW/8-1:0] wen_n
  );
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DW/8; i++) begin
      m[i*8 +: 8] = {8{~wen_n[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/aha_sram_bank.sv
// aha_sram_bank: wrapper around one single-port macro bank.
// Maps CEn/WEn onto the macro CEN/RDWEN/BW pins; test mode tied off.
module aha_sram_bank
  import aha_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 13
) (
  input  logic                    CLK,
  input  logic                    CEn,
  input  logic [DATA_WIDTH/8-1:0] WEn,
  input  logic [AW-1:0]           A,
  input  logic [DATA_WIDTH-1:0]   D,
  output logic [DATA_WIDTH-1:0]   Q
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  cen;
  logic                  rdwen;
  logic                  ten;
  logic [MAX_DW-1:0]     bw_full;
  logic [DATA_WIDTH-1:0] bw;
  logic                  bw_unused;

  logic [DATA_WIDTH-1:0] mem [1<<AW];
  logic [DATA_WIDTH-1:0] q_q;

  assign cen       = CEn;
  assign rdwen     = &WEn;
  assign ten       = 1'b0;
  assign bw_full   = be_mask({{(MAX_DW/8-NBYTES){1'b1}}, WEn});
  assign bw        = bw_full[DATA_WIDTH-1:0];
  assign bw_unused = ^bw_full[MAX_DW-1:DATA_WIDTH];
  assign Q         = q_q;

  // Macro behaviour: masked write, or read into the output latch.
  always_ff @(posedge CLK) begin
    if (!cen && !ten) begin
      if (rdwen) begin
        q_q <= mem[A];
      end else begin
        mem[A] <= (mem[A] & ~bw) | (D & bw);
      end
    end
  end

endmodule

// File: rtl/aha_sram_banked.sv
// aha_sram_banked: one logical SRAM built from 2^(AW-BAW) macro banks.
// Bank decode, registered read mux, optional output reg, zero-fill on reset.
module aha_sram_banked
  import aha_sram_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 15,
  parameter int BANK_ADDR_WIDTH = 13,
  parameter int OUT_REG         = 1,
  parameter int INIT_ON_RESET   = 1
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic                    CEn,
  input  logic [DATA_WIDTH/8-1:0] WEn,
  input  logic [ADDR_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   D,
  output logic [DATA_WIDTH-1:0]   Q,
  output logic                    RVALID,
  output logic                    READY
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int NBANKS = nbanks(ADDR_WIDTH, BANK_ADDR_WIDTH);
  localparam int SELW   = (NBANKS > 1) ?
                          ADDR_WIDTH - BANK_ADDR_WIDTH : 1;
  localparam init_st_e RST_ST = (INIT_ON_RESET != 0) ?
                                ST_INIT : ST_READY;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH >= MAX_DW) begin : g_bad_dw
    $fatal(1, "DATA_WIDTH must be a multiple of 8");
  end
  if (BANK_ADDR_WIDTH > ADDR_WIDTH) begin : g_bad_aw
    $fatal(1, "BANK_ADDR_WIDTH exceeds ADDR_WIDTH");
  end

  init_st_e                   state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                       init;
  logic                       acc;
  logic                       rd;
  logic [SELW-1:0]            bsel;
  logic [BANK_ADDR_WIDTH-1:0] bank_a;
  logic [SELW-1:0]            sel_q;
  logic                       rd_q;
  logic [DATA_WIDTH-1:0]      mux_q;
  logic [DATA_WIDTH-1:0]      bank_q [NBANKS];

  assign init   = (state_q == ST_INIT);
  assign READY  = (state_q == ST_READY);
  assign acc    = !CEn && READY;
  assign rd     = acc && (&WEn);
  assign bank_a = A[BANK_ADDR_WIDTH-1:0];

  if (NBANKS > 1) begin : g_dec
    assign bsel = A[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
  end else begin : g_nodec
    assign bsel = '0;
  end

  // Init FSM state and zero-fill counter.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk every bank address once, then stay ready until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == '1) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = state_q;
    endcase
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic                       cen_n;
    logic [NBYTES-1:0]          wen_n;
    logic [BANK_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      din;

    assign cen_n = init ? 1'b0 : ~(acc && (bsel == SELW'(b)));
    assign wen_n = init ? '0 : WEn;
    assign addr  = init ? cnt_q : bank_a;
    assign din   = init ? '0 : D;

    aha_sram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (BANK_ADDR_WIDTH)
    ) u_bank (
      .CLK (CLK),
      .CEn (cen_n),
      .WEn (wen_n),
      .A   (addr),
      .D   (din),
      .Q   (bank_q[b])
    );
  end

  // Remember which bank a read went to and that a result is due.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sel_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      rd_q <= rd;
      if (rd) begin
        sel_q <= bsel;
      end
    end
  end

  // Read-data mux driven by the registered bank select.
  always_comb begin
    mux_q = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (sel_q == SELW'(b)) begin
        mux_q = bank_q[b];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] q_q;
    logic                  rv_q;

    // Output pipeline stage; Q only moves on a completed read.
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        q_q  <= '0;
        rv_q <= 1'b0;
      end else begin
        rv_q <= rd_q;
        if (rd_q) begin
          q_q <= mux_q;
        end
      end
    end

    assign Q      = q_q;
    assign RVALID = rv_q;
  end else begin : g_noreg
    logic seen_q;

    // Masks the unread macro latch until the first read lands.
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        seen_q <= 1'b0;
      end else if (rd) begin
        seen_q <= 1'b1;
      end
    end

    assign Q      = seen_q ? mux_q : '0;
    assign RVALID = rd_q;
  end

endmodule

// File: tb/tb_aha_sram_banked.sv
// tb_aha_sram_banked: scoreboard bench for two configurations.
// Default 4-bank registered build, and 1-bank unregistered no-init build.
module tb_aha_sram_banked;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic        ra_n = 1'b0;
  logic        a_cen = 1'b1;
  logic [3:0]  a_wen = 4'hF;
  logic [14:0] a_addr = '0;
  logic [31:0] a_d = '0;
  logic [31:0] a_q;
  logic        a_rv, a_rdy;

  logic        rb_n = 1'b0;
  logic        b_cen = 1'b1;
  logic [3:0]  b_wen = 4'hF;
  logic [9:0]  b_addr = '0;
  logic [31:0] b_d = '0;
  logic [31:0] b_q;
  logic        b_rv, b_rdy;

  aha_sram_banked u_a (
    .CLK (clk), .RESETn (ra_n), .CEn (a_cen), .WEn (a_wen),
    .A (a_addr), .D (a_d), .Q (a_q), .RVALID (a_rv), .READY (a_rdy)
  );

  aha_sram_banked #(
    .DATA_WIDTH (32), .ADDR_WIDTH (10), .BANK_ADDR_WIDTH (10),
    .OUT_REG (0), .INIT_ON_RESET (0)
  ) u_b (
    .CLK (clk), .RESETn (rb_n), .CEn (b_cen), .WEn (b_wen),
    .A (b_addr), .D (b_d), .Q (b_q), .RVALID (b_rv), .READY (b_rdy)
  );

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (!wen[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] peek_a(input int addr);
    return mem_a.exists(addr) ? mem_a[addr] : 32'h0;
  endfunction

  function automatic logic [31:0] peek_b(input int addr);
    return mem_b.exists(addr) ? mem_b[addr] : 32'h0;
  endfunction

  task automatic a_acc(input bit cen, input logic [3:0] wen,
                       input logic [14:0] addr, input logic [31:0] d);
    @(negedge clk);
    a_cen = cen; a_wen = wen; a_addr = addr; a_d = d;
    if (!cen) begin
      if (&wen) qa.push_back('{data: peek_a(int'(addr)), at: cyc + 2});
      else mem_a[int'(addr)] = merge(peek_a(int'(addr)), d, wen);
    end
  endtask

  task automatic b_acc(input bit cen, input logic [3:0] wen,
                       input logic [9:0] addr, input logic [31:0] d);
    @(negedge clk);
    b_cen = cen; b_wen = wen; b_addr = addr; b_d = d;
    if (!cen) begin
      if (&wen) qb.push_back('{data: peek_b(int'(addr)), at: cyc + 1});
      else mem_b[int'(addr)] = merge(peek_b(int'(addr)), d, wen);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (a_rv === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_rvalid_unexpected", 32'(qa.size()), 32'd1);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rdata", a_q, e.data);
        chk("a_rlatency", 32'(cyc), 32'(e.at));
      end
    end else if (qa.size() > 0 && qa[0].at <= cyc) begin
      chk("a_rvalid_missing", {31'b0, a_rv}, 32'd1);
      void'(qa.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_rv === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_rvalid_unexpected", 32'(qb.size()), 32'd1);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rdata", b_q, e.data);
        chk("b_rlatency", 32'(cyc), 32'(e.at));
      end
    end else if (qb.size() > 0 && qb[0].at <= cyc) begin
      chk("b_rvalid_missing", {31'b0, b_rv}, 32'd1);
      void'(qb.pop_front());
    end
  end

  task automatic wait_ready_a(output int n, input bit poke);
    n = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (a_rdy) break;
      if (poke && i == 20) begin
        a_cen = 1'b0; a_wen = 4'h0; a_addr = 15'h0005; a_d = '1;
      end else if (poke && i == 21) begin
        a_cen = 1'b0; a_wen = 4'hF; a_addr = 15'h2005;
      end else if (poke && i == 22) begin
        a_cen = 1'b1;
      end
    end
    if (!a_rdy) chk("a_ready_timeout", {31'b0, a_rdy}, 32'd1);
  endtask

  initial begin
    int n;
    logic [14:0] pool_a [5];
    pool_a = '{15'h0010, 15'h0011, 15'h2010, 15'h4123, 15'h7FFF};

    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_q", a_q, 32'h0);
    chk("a_rst_rvalid", {31'b0, a_rv}, 32'h0);
    chk("a_rst_ready", {31'b0, a_rdy}, 32'h0);
    chk("b_rst_q", b_q, 32'h0);
    chk("b_rst_ready", {31'b0, b_rdy}, 32'h1);

    @(negedge clk);
    ra_n = 1'b1;
    rb_n = 1'b1;
    repeat (3) @(negedge clk);
    a_cen = 1'b0; a_wen = 4'hF; a_addr = 15'h0000;
    @(negedge clk);
    a_cen = 1'b1;
    repeat (96) @(posedge clk);
    #1;
    chk("a_ready_mid_init", {31'b0, a_rdy}, 32'h0);
    ra_n = 1'b0;
    #1;
    chk("a_rst2_q", a_q, 32'h0);
    chk("a_rst2_rvalid", {31'b0, a_rv}, 32'h0);
    @(negedge clk);
    ra_n = 1'b1;
    wait_ready_a(n, 1'b1);
    chk("a_init_cycles", 32'(n), 32'd8192);

    a_acc(0, 4'hF, 15'h0000, '0);
    a_acc(0, 4'hF, 15'h1FFF, '0);
    a_acc(0, 4'hF, 15'h2000, '0);
    a_acc(0, 4'hF, 15'h7FFF, '0);
    a_acc(0, 4'hF, 15'h0005, '0);
    a_acc(0, 4'hF, 15'h2005, '0);

    a_acc(0, 4'h0, 15'h4123, 32'hDEADBEEF);
    a_acc(0, 4'hF, 15'h4123, '0);
    a_acc(0, 4'h0, 15'h0010, 32'h11223344);
    a_acc(0, 4'hA, 15'h0010, 32'hAABBCCDD);
    a_acc(0, 4'hF, 15'h0010, '0);
    a_acc(1, 4'hF, 15'h0000, '0);
    repeat (3) @(negedge clk);
    chk("a_partial_write", a_q, 32'h11BB33DD);

    a_acc(0, 4'h0, 15'h1FFF, 32'h1);
    a_acc(0, 4'h0, 15'h2000, 32'h2);
    a_acc(0, 4'hF, 15'h1FFF, '0);
    a_acc(0, 4'hF, 15'h2000, '0);
    a_acc(0, 4'h0, 15'h2000, 32'h99);
    a_acc(0, 4'h0, 15'h1FFF, 32'h77);
    a_acc(1, 4'hF, 15'h0000, '0);
    repeat (4) @(negedge clk);
    chk("a_q_hold", a_q, 32'h2);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [14:0] ad;
      r  = int'($urandom_range(0, 9));
      ad = ($urandom_range(0, 1) == 0) ? pool_a[$urandom_range(0, 4)]
                                        : 15'($urandom_range(0, 32767));
      if (r < 2) a_acc(1, 4'hF, ad, '0);
      else if (r < 6) a_acc(0, 4'hF, ad, '0);
      else a_acc(0, 4'($urandom_range(0, 14)), ad, $urandom);
    end
    a_acc(1, 4'hF, 15'h0000, '0);
    repeat (5) @(negedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);

    b_acc(0, 4'h0, 10'h3FF, 32'h5A5A5A5A);
    b_acc(1, 4'hF, 10'h000, '0);
    chk("b_q_before_read", b_q, 32'h0);
    b_acc(0, 4'hF, 10'h3FF, '0);
    b_acc(0, 4'h0, 10'h3FF, 32'h12345678);
    b_acc(1, 4'hF, 10'h000, '0);
    chk("b_q_hold", b_q, 32'h5A5A5A5A);
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [9:0] ad;
      r  = int'($urandom_range(0, 9));
      ad = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 3))
                                        : 10'($urandom_range(0, 1023));
      if (r < 2) b_acc(1, 4'hF, ad, '0);
      else if (r < 6) b_acc(0, 4'hF, ad, '0);
      else b_acc(0, 4'($urandom_range(0, 14)), ad, $urandom);
    end
    b_acc(1, 4'hF, 10'h000, '0);
    repeat (4) @(negedge clk);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
